// File: rtl/axis32_tx_arb_pkg.sv
// Shared types for the two-port AXI-Stream TX arbiter.
// Grant-state encodings, beat bundle and tvldb sizing.
package axis32_tx_arb_pkg;

    // tvldb value meaning "all four bytes valid"
    localparam logic [1:0] P_TVLDB_FULL = 2'd3;

    typedef logic [$clog2(int'(P_TVLDB_FULL) + 1)-1:0] vldb_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'b001,
        P_GNT0 = 3'b010,
        P_GNT1 = 3'b100
    } arb_state_e;

    typedef struct packed {
        logic [31:0] tdata;
        vldb_t       tvldb;
        logic        tvalid;
        logic        tlast;
        logic        tuser;
    } axis_beat_t;

    localparam axis_beat_t BEAT_IDLE = '0;

endpackage

// File: rtl/axis32_rr_pick.sv
// Next-grant picker for the idle state of the TX arbiter.
// Round-robin on ties, or fixed port-0 priority when strict.
module axis32_rr_pick #(
    parameter bit P_STRICT_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    // A tie goes to port 0 when strict or when port 1 was served last.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            if (P_STRICT_PRIO || last_grant) begin
                pick = 2'b01;
            end else begin
                pick = 2'b10;
            end
        end
    end

endmodule

// File: rtl/axis32_tx_arb.sv
// Two-port frame-atomic AXI-Stream arbiter feeding the MAC TX path.
// Zero-latency mux; a grant is held until the frame's last beat.
module axis32_tx_arb
    import axis32_tx_arb_pkg::*;
#(
    parameter bit P_STRICT_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  cfg_en_i,
    input  logic [31:0] s0_tdata_i,
    input  logic [1:0]  s0_tvldb_i,
    input  logic        s0_tvalid_i,
    input  logic        s0_tlast_i,
    input  logic        s0_tuser_i,
    output logic        s0_tready_o,
    input  logic [31:0] s1_tdata_i,
    input  logic [1:0]  s1_tvldb_i,
    input  logic        s1_tvalid_i,
    input  logic        s1_tlast_i,
    input  logic        s1_tuser_i,
    output logic        s1_tready_o,
    output logic [31:0] m_tdata_o,
    output logic [1:0]  m_tvldb_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    input  logic        m_tready_i,
    output logic [31:0] frames0_o,
    output logic [31:0] frames1_o,
    output logic [1:0]  grant_o
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       last_grant;
    logic [1:0] req;
    logic [1:0] pick;
    logic       done0;
    logic       done1;
    axis_beat_t s0_beat;
    axis_beat_t s1_beat;
    axis_beat_t m_beat;

    assign s0_beat = {s0_tdata_i, s0_tvldb_i, s0_tvalid_i,
                      s0_tlast_i, s0_tuser_i};
    assign s1_beat = {s1_tdata_i, s1_tvldb_i, s1_tvalid_i,
                      s1_tlast_i, s1_tuser_i};

    // Live cfg_en_i gates requests; it never interrupts a frame.
    assign req = {s1_tvalid_i & cfg_en_i[1],
                  s0_tvalid_i & cfg_en_i[0]};

    assign {m_tdata_o, m_tvldb_o, m_tvalid_o,
            m_tlast_o, m_tuser_o} = m_beat;

    assign grant_o = {state == P_GNT1, state == P_GNT0};

    axis32_rr_pick #(
        .P_STRICT_PRIO(P_STRICT_PRIO)
    ) u_pick (
        .req       (req),
        .last_grant(last_grant),
        .pick      (pick)
    );

    // Next state, output mux and last-beat detection.
    always_comb begin
        state_nxt   = state;
        m_beat      = BEAT_IDLE;
        s0_tready_o = 1'b0;
        s1_tready_o = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        unique case (state)
            P_IDLE: begin
                if (pick[0]) begin
                    state_nxt = P_GNT0;
                end else if (pick[1]) begin
                    state_nxt = P_GNT1;
                end
            end
            P_GNT0: begin
                m_beat      = s0_beat;
                s0_tready_o = m_tready_i;
                if (s0_tvalid_i && m_tready_i && s0_tlast_i) begin
                    done0     = 1'b1;
                    state_nxt = req[1] ? P_GNT1 : P_IDLE;
                end
            end
            P_GNT1: begin
                m_beat      = s1_beat;
                s1_tready_o = m_tready_i;
                if (s1_tvalid_i && m_tready_i && s1_tlast_i) begin
                    done1     = 1'b1;
                    state_nxt = req[0] ? P_GNT0 : P_IDLE;
                end
            end
            default: begin
                state_nxt = P_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and per-port frame counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= P_IDLE;
            last_grant <= 1'b1;
            frames0_o  <= '0;
            frames1_o  <= '0;
        end else begin
            state <= state_nxt;
            if (done0) begin
                frames0_o  <= frames0_o + 32'd1;
                last_grant <= 1'b0;
            end
            if (done1) begin
                frames1_o  <= frames1_o + 32'd1;
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis32_tx_arb.sv
// Directed bench for axis32_tx_arb, round-robin and strict builds.
// Beat data encodes port/frame/beat so the served source is visible.
module tb_axis32_tx_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  cfg_en_i;
    logic [31:0] s0_tdata_i, s1_tdata_i;
    logic [1:0]  s0_tvldb_i, s1_tvldb_i;
    logic        s0_tvalid_i, s1_tvalid_i;
    logic        s0_tlast_i, s1_tlast_i;
    logic        s0_tuser_i, s1_tuser_i;
    logic        m_tready_i;

    logic        s0_tready_o, s1_tready_o;
    logic [31:0] m_tdata_o;
    logic [1:0]  m_tvldb_o;
    logic        m_tvalid_o, m_tlast_o, m_tuser_o;
    logic [31:0] frames0_o, frames1_o;
    logic [1:0]  grant_o;

    logic        sp_s0_tready_o, sp_s1_tready_o;
    logic [31:0] sp_m_tdata_o;
    logic [1:0]  sp_m_tvldb_o;
    logic        sp_m_tvalid_o, sp_m_tlast_o, sp_m_tuser_o;
    logic [31:0] sp_frames0_o, sp_frames1_o;
    logic [1:0]  sp_grant_o;

    int nchk = 0;
    int nfail = 0;
    int nf[2];
    int len[2];
    int fi[2];
    int bi[2];
    bit sel_sp = 1'b0;

    always #5 clk = ~clk;

    axis32_tx_arb #(.P_STRICT_PRIO(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
        .s0_tdata_i(s0_tdata_i), .s0_tvldb_i(s0_tvldb_i),
        .s0_tvalid_i(s0_tvalid_i), .s0_tlast_i(s0_tlast_i),
        .s0_tuser_i(s0_tuser_i), .s0_tready_o(s0_tready_o),
        .s1_tdata_i(s1_tdata_i), .s1_tvldb_i(s1_tvldb_i),
        .s1_tvalid_i(s1_tvalid_i), .s1_tlast_i(s1_tlast_i),
        .s1_tuser_i(s1_tuser_i), .s1_tready_o(s1_tready_o),
        .m_tdata_o(m_tdata_o), .m_tvldb_o(m_tvldb_o),
        .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o),
        .m_tuser_o(m_tuser_o), .m_tready_i(m_tready_i),
        .frames0_o(frames0_o), .frames1_o(frames1_o),
        .grant_o(grant_o)
    );

    axis32_tx_arb #(.P_STRICT_PRIO(1'b1)) u_sp (
        .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
        .s0_tdata_i(s0_tdata_i), .s0_tvldb_i(s0_tvldb_i),
        .s0_tvalid_i(s0_tvalid_i), .s0_tlast_i(s0_tlast_i),
        .s0_tuser_i(s0_tuser_i), .s0_tready_o(sp_s0_tready_o),
        .s1_tdata_i(s1_tdata_i), .s1_tvldb_i(s1_tvldb_i),
        .s1_tvalid_i(s1_tvalid_i), .s1_tlast_i(s1_tlast_i),
        .s1_tuser_i(s1_tuser_i), .s1_tready_o(sp_s1_tready_o),
        .m_tdata_o(sp_m_tdata_o), .m_tvldb_o(sp_m_tvldb_o),
        .m_tvalid_o(sp_m_tvalid_o), .m_tlast_o(sp_m_tlast_o),
        .m_tuser_o(sp_m_tuser_o), .m_tready_i(m_tready_i),
        .frames0_o(sp_frames0_o), .frames1_o(sp_frames1_o),
        .grant_o(sp_grant_o)
    );

    function automatic logic [31:0] mk(int p, int f, int b);
        return 32'hA000_0000 + 32'(p) * 32'h0100_0000
             + 32'(f) * 32'h0001_0000 + 32'(b);
    endfunction

    task automatic drive();
        s0_tvalid_i = (fi[0] < nf[0]);
        s0_tdata_i  = mk(0, fi[0], bi[0]);
        s0_tlast_i  = (bi[0] == len[0] - 1);
        s0_tvldb_i  = 2'(bi[0]);
        s0_tuser_i  = 1'b1;
        s1_tvalid_i = (fi[1] < nf[1]);
        s1_tdata_i  = mk(1, fi[1], bi[1]);
        s1_tlast_i  = (bi[1] == len[1] - 1);
        s1_tvldb_i  = 2'(bi[1]);
        s1_tuser_i  = 1'b1;
    endtask

    task automatic start(int n0, int l0, int n1, int l1);
        nf[0] = n0; len[0] = l0; fi[0] = 0; bi[0] = 0;
        nf[1] = n1; len[1] = l1; fi[1] = 0; bi[1] = 0;
        drive();
    endtask

    // Called after a negedge: latch handshakes, cross the edge, step sources.
    task automatic advance();
        logic h0, h1;
        h0 = s0_tvalid_i & (sel_sp ? sp_s0_tready_o : s0_tready_o);
        h1 = s1_tvalid_i & (sel_sp ? sp_s1_tready_o : s1_tready_o);
        @(posedge clk);
        #1;
        if (h0) begin
            if (bi[0] == len[0] - 1) begin bi[0] = 0; fi[0]++; end
            else bi[0]++;
        end
        if (h1) begin
            if (bi[1] == len[1] - 1) begin bi[1] = 0; fi[1]++; end
            else bi[1]++;
        end
        drive();
    endtask

    task automatic do_reset();
        start(0, 1, 0, 1);
        cfg_en_i   = 2'b11;
        m_tready_i = 1'b1;
        rst_i      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        start(0, 1, 0, 1);
        cfg_en_i   = 2'b11;
        m_tready_i = 1'b1;
        rst_i      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nf[0] = 1; nf[1] = 1;
        drive();
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tvalid_o, s0_tready_o, s1_tready_o} !== 5'b0) begin
            nfail++;
            $display("FAIL rst_hold: grant=%b valid=%b rdy=%b%b want 00 0 00",
                     grant_o, m_tvalid_o, s0_tready_o, s1_tready_o);
        end
        nchk++;
        if ({frames0_o, frames1_o} !== 64'd0) begin
            nfail++;
            $display("FAIL rst_cnt: frames0=%0d frames1=%0d want 0 0",
                     frames0_o, frames1_o);
        end
        nchk++;
        if ({m_tdata_o, m_tvldb_o, m_tlast_o, m_tuser_o} !== 36'd0) begin
            nfail++;
            $display("FAIL rst_data: data=%h vldb=%b last=%b user=%b want 0",
                     m_tdata_o, m_tvldb_o, m_tlast_o, m_tuser_o);
        end
        nchk++;
        if ({sp_grant_o, sp_frames0_o, sp_frames1_o} !== 66'd0) begin
            nfail++;
            $display("FAIL rst_strict: grant=%b f0=%0d f1=%0d want 00 0 0",
                     sp_grant_o, sp_frames0_o, sp_frames1_o);
        end
    endtask

    task automatic test_round_robin();
        int g[14] = '{0, 1, 1, 1, 2, 2, 2, 1, 1, 1, 2, 2, 2, 0};
        int f[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        int b[14] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        logic [31:0] ed;
        do_reset();
        start(2, 3, 2, 3);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            ed = (g[c] == 0) ? 32'd0 : mk(g[c] >> 1, f[c], b[c]);
            nchk++;
            if ({grant_o, m_tvalid_o, m_tdata_o} !== {2'(g[c]), g[c] != 0, ed}) begin
                nfail++;
                $display("FAIL rr c%0d: grant=%b valid=%b data=%h want %b %b %h",
                         c, grant_o, m_tvalid_o, m_tdata_o, 2'(g[c]), g[c] != 0, ed);
            end
            if (c == 10) begin
                nchk++;
                if ({frames0_o, frames1_o} !== {32'd2, 32'd1}) begin
                    nfail++;
                    $display("FAIL rr_cnt: frames0=%0d frames1=%0d want 2 1",
                             frames0_o, frames1_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int g[7] = '{0, 1, 1, 0, 1, 1, 0};
        int f[7] = '{0, 0, 0, 0, 1, 1, 0};
        int b[7] = '{0, 0, 1, 0, 0, 1, 0};
        logic [31:0] ed;
        do_reset();
        start(2, 2, 0, 1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ed = (g[c] == 0) ? 32'd0 : mk(g[c] >> 1, f[c], b[c]);
            nchk++;
            if ({grant_o, m_tvalid_o, m_tdata_o} !== {2'(g[c]), g[c] != 0, ed}) begin
                nfail++;
                $display("FAIL b2b c%0d: grant=%b valid=%b data=%h want %b %b %h",
                         c, grant_o, m_tvalid_o, m_tdata_o, 2'(g[c]), g[c] != 0, ed);
            end
            advance();
        end
        nchk++;
        if ({frames0_o, frames1_o} !== {32'd2, 32'd0}) begin
            nfail++;
            $display("FAIL b2b_cnt: frames0=%0d frames1=%0d want 2 0",
                     frames0_o, frames1_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        start(0, 2, 1, 4);
        @(negedge clk);
        nchk++;
        if (grant_o !== 2'b00) begin
            nfail++;
            $display("FAIL stall_idle: grant=%b want 00", grant_o);
        end
        advance();
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            nchk++;
            if ({grant_o, m_tdata_o} !== {2'b10, mk(1, 0, c - 1)}) begin
                nfail++;
                $display("FAIL stall_pre c%0d: grant=%b data=%h want 10 %h",
                         c, grant_o, m_tdata_o, mk(1, 0, c - 1));
            end
            advance();
        end
        m_tready_i = 1'b0;
        nf[0] = 1;
        drive();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nchk++;
            if ({grant_o, m_tdata_o, s1_tready_o, s0_tready_o, frames1_o}
                !== {2'b10, mk(1, 0, 2), 2'b00, 32'd0}) begin
                nfail++;
                $display("FAIL stall c%0d: grant=%b data=%h rdy1=%b rdy0=%b f1=%0d want 10 %h 0 0 0",
                         c, grant_o, m_tdata_o, s1_tready_o, s0_tready_o,
                         frames1_o, mk(1, 0, 2));
            end
            advance();
        end
        m_tready_i = 1'b1;
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tdata_o, s1_tready_o} !== {2'b10, mk(1, 0, 2), 1'b1}) begin
            nfail++;
            $display("FAIL stall_resume: grant=%b data=%h rdy1=%b want 10 %h 1",
                     grant_o, m_tdata_o, s1_tready_o, mk(1, 0, 2));
        end
        advance();
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tdata_o, m_tlast_o, frames1_o}
            !== {2'b10, mk(1, 0, 3), 1'b1, 32'd0}) begin
            nfail++;
            $display("FAIL stall_last: grant=%b data=%h last=%b f1=%0d want 10 %h 1 0",
                     grant_o, m_tdata_o, m_tlast_o, frames1_o, mk(1, 0, 3));
        end
        advance();
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tdata_o, frames1_o} !== {2'b01, mk(0, 0, 0), 32'd1}) begin
            nfail++;
            $display("FAIL stall_handoff: grant=%b data=%h f1=%0d want 01 %h 1",
                     grant_o, m_tdata_o, frames1_o, mk(0, 0, 0));
        end
    endtask

    task automatic test_cfg_disable();
        int g[9] = '{0, 1, 1, 1, 1, 2, 2, 0, 0};
        int b[9] = '{0, 0, 1, 2, 3, 0, 1, 0, 0};
        logic [31:0] ed;
        do_reset();
        start(2, 4, 1, 2);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            ed = (g[c] == 0) ? 32'd0 : mk(g[c] >> 1, 0, b[c]);
            nchk++;
            if ({grant_o, m_tvalid_o, m_tdata_o} !== {2'(g[c]), g[c] != 0, ed}) begin
                nfail++;
                $display("FAIL cfg c%0d: grant=%b valid=%b data=%h want %b %b %h",
                         c, grant_o, m_tvalid_o, m_tdata_o, 2'(g[c]), g[c] != 0, ed);
            end
            advance();
            if (c == 1) cfg_en_i = 2'b10;
        end
        nchk++;
        if ({frames0_o, frames1_o} !== {32'd1, 32'd1}) begin
            nfail++;
            $display("FAIL cfg_cnt: frames0=%0d frames1=%0d want 1 1",
                     frames0_o, frames1_o);
        end
    endtask

    task automatic test_strict();
        int g[9] = '{0, 1, 1, 0, 1, 1, 2, 2, 0};
        int f[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
        int b[9] = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
        logic [31:0] ed;
        sel_sp = 1'b1;
        do_reset();
        start(1, 2, 0, 2);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            ed = (g[c] == 0) ? 32'd0 : mk(g[c] >> 1, f[c], b[c]);
            nchk++;
            if ({sp_grant_o, sp_m_tvalid_o, sp_m_tdata_o}
                !== {2'(g[c]), g[c] != 0, ed}) begin
                nfail++;
                $display("FAIL strict c%0d: grant=%b valid=%b data=%h want %b %b %h",
                         c, sp_grant_o, sp_m_tvalid_o, sp_m_tdata_o,
                         2'(g[c]), g[c] != 0, ed);
            end
            advance();
            if (c == 2) begin
                nf[0] = 2;
                nf[1] = 1;
                drive();
            end
        end
        nchk++;
        if ({sp_frames0_o, sp_frames1_o} !== {32'd2, 32'd1}) begin
            nfail++;
            $display("FAIL strict_cnt: frames0=%0d frames1=%0d want 2 1",
                     sp_frames0_o, sp_frames1_o);
        end
        sel_sp = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int g[7] = '{0, 1, 2, 2, 2, 0, 2};
        int f[7] = '{0, 0, 0, 0, 0, 0, 1};
        int b[7] = '{0, 0, 0, 1, 2, 0, 0};
        logic [31:0] ed;
        do_reset();
        start(1, 1, 2, 3);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ed = (g[c] == 0) ? 32'd0 : mk(g[c] >> 1, f[c], b[c]);
            nchk++;
            if ({grant_o, m_tvalid_o, m_tdata_o} !== {2'(g[c]), g[c] != 0, ed}) begin
                nfail++;
                $display("FAIL rmid c%0d: grant=%b valid=%b data=%h want %b %b %h",
                         c, grant_o, m_tvalid_o, m_tdata_o, 2'(g[c]), g[c] != 0, ed);
            end
            advance();
        end
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tvldb_o, m_tuser_o, frames0_o, frames1_o}
            !== {2'b10, 2'b01, 1'b1, 32'd1, 32'd1}) begin
            nfail++;
            $display("FAIL rmid_beat2: grant=%b vldb=%b user=%b f0=%0d f1=%0d want 10 01 1 1 1",
                     grant_o, m_tvldb_o, m_tuser_o, frames0_o, frames1_o);
        end
        rst_i = 1'b1;
        advance();
        rst_i = 1'b0;
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tvalid_o, m_tvldb_o, m_tuser_o, m_tlast_o,
             s1_tready_o, frames0_o, frames1_o} !== 72'd0) begin
            nfail++;
            $display("FAIL rmid_after: grant=%b valid=%b vldb=%b user=%b last=%b rdy1=%b f0=%0d f1=%0d want all 0",
                     grant_o, m_tvalid_o, m_tvldb_o, m_tuser_o, m_tlast_o,
                     s1_tready_o, frames0_o, frames1_o);
        end
        advance();
        @(negedge clk);
        nchk++;
        if ({grant_o, m_tdata_o} !== {2'b10, mk(1, 1, 2)}) begin
            nfail++;
            $display("FAIL rmid_regrant: grant=%b data=%h want 10 %h",
                     grant_o, m_tdata_o, mk(1, 1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_cfg_disable();
        test_strict();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
